// File: rtl/cavity_mux_model.sv
// ----------------------------------------------------------------------------
// cavity_mux_model
//
// Time-multiplexed emulator of NCH first-order detuned cavities. One
// interleaved IQ drive stream comes in (ch0 I, ch0 Q, ch1 I, ...). The
// cavity field and the reflected wave go out in the same interleaved order,
// one cycle later. Each channel has its own host-programmable bandwidth
// shift and detune coefficient.
//
// Ports
//   clk, rst      system clock, asynchronous active-high reset
//   in_valid      drive sample valid this cycle
//   in_first      drive sample is channel 0 I (frame start)
//   drive         signed drive sample (W bits)
//   out_valid     field/reflect valid (in_valid delayed one cycle)
//   out_first     output sample is channel 0 I
//   field         signed cavity field sample (W bits)
//   reflect       signed reflected wave sample (W bits)
//   cfg_we        configuration write strobe
//   cfg_addr      channel to configure (addresses >= NCH are ignored)
//   cfg_detune    signed detune coefficient, scaled by 2^17
//   cfg_bw        bandwidth shift 0..15
//   err_clr       clears frame_err
//   frame_err     sticky frame misalignment flag
// ----------------------------------------------------------------------------
module cavity_mux_model #(
    parameter int NCH    = 4,
    parameter int CHW    = 2,
    parameter int W      = 18,
    parameter int BW_DEF = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic                in_first,
    input  logic signed [W-1:0] drive,
    output logic                out_valid,
    output logic                out_first,
    output logic signed [W-1:0] field,
    output logic signed [W-1:0] reflect,
    input  logic                cfg_we,
    input  logic [CHW-1:0]      cfg_addr,
    input  logic signed [17:0]  cfg_detune,
    input  logic [3:0]          cfg_bw,
    input  logic                err_clr,
    output logic                frame_err
);

    localparam int SW = CHW + 1;  // slot counter width, slots 0..2*NCH-1
    localparam int EW = W + 3;    // error term width
    localparam int PW = W + 18;   // detune * state product width

    localparam logic [SW-1:0]        LAST_SLOT = SW'(2 * NCH - 1);
    localparam logic signed [EW-1:0] SAT_MAX   = EW'((2 ** (W - 1)) - 1);
    localparam logic signed [EW-1:0] SAT_MIN   = ~SAT_MAX;

    // Clamp a wide intermediate to the W-bit signed range.
    function automatic logic signed [W-1:0] sat_w(input logic signed [EW-1:0] v);
        if (v > SAT_MAX)
            return SAT_MAX[W-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[W-1:0];
        else
            return v[W-1:0];
    endfunction

    // Per-channel state and configuration
    logic signed [W-1:0] r_yi  [NCH];
    logic signed [W-1:0] r_yq  [NCH];
    logic signed [17:0]  r_det [NCH];
    logic [3:0]          r_bw  [NCH];

    logic [SW-1:0]       r_slot;
    logic                r_out_valid;
    logic                r_out_first;
    logic signed [W-1:0] r_field;
    logic signed [W-1:0] r_reflect;
    logic                r_frame_err;

    logic [SW-1:0]       w_slot;
    logic [SW-1:0]       w_slot_nxt;
    logic [CHW-1:0]      w_ch;
    logic                w_is_q;
    logic signed [W-1:0] w_y_self;
    logic signed [W-1:0] w_y_oth;
    logic signed [PW-1:0] w_prod;
    logic signed [EW-1:0] w_coup;
    logic signed [EW-1:0] w_e;
    logic signed [EW-1:0] w_step;
    logic signed [EW-1:0] w_sum;
    logic signed [W-1:0] w_new;
    logic signed [W-1:0] w_refl;
    logic                w_ferr;
    logic                w_cfg_ok;

    // in_first forces the sample to slot 0 whatever the counter says; a
    // counter at 0 without in_first is equally a frame start.
    assign w_slot     = in_first ? '0 : r_slot;
    assign w_slot_nxt = (w_slot == LAST_SLOT) ? '0 : w_slot + 1'b1;
    assign w_ch       = w_slot[SW-1:1];
    assign w_is_q     = w_slot[0];
    assign w_ferr     = in_valid & in_first & (r_slot != '0);
    assign w_cfg_ok   = {1'b0, cfg_addr} < SW'(NCH);

    // The Q slot reads r_yi, which already holds the value written in this
    // frame's I slot, so the cross-coupling uses the fresh I state.
    assign w_y_self = w_is_q ? r_yq[w_ch] : r_yi[w_ch];
    assign w_y_oth  = w_is_q ? r_yi[w_ch] : r_yq[w_ch];
    assign w_prod   = PW'(r_det[w_ch]) * PW'(w_y_oth);
    assign w_coup   = EW'(w_prod >>> 17);

    // I: e = x - yI + d*yQ ; Q: e = x - yQ - d*yI. Shifts are arithmetic,
    // so the bandwidth step rounds toward minus infinity.
    assign w_e    = EW'(drive) - EW'(w_y_self) + (w_is_q ? -w_coup : w_coup);
    assign w_step = w_e >>> r_bw[w_ch];
    assign w_sum  = EW'(w_y_self) + w_step;
    assign w_new  = sat_w(w_sum);
    assign w_refl = sat_w(EW'(drive) - EW'(w_new));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot      <= '0;
            r_out_valid <= 1'b0;
            r_out_first <= 1'b0;
            r_field     <= '0;
            r_reflect   <= '0;
            r_frame_err <= 1'b0;
            // NOTE: the per-channel arrays sit in the reset branch on purpose:
            // a reset must return every cavity to rest and every channel to
            // the default bandwidth, so they are flops, not a RAM.
            for (int c = 0; c < NCH; c++) begin
                r_yi[c]  <= '0;
                r_yq[c]  <= '0;
                r_det[c] <= '0;
                r_bw[c]  <= 4'(BW_DEF);
            end
        end else begin
            r_out_valid <= in_valid;

            if (in_valid) begin
                if (w_is_q)
                    r_yq[w_ch] <= w_new;
                else
                    r_yi[w_ch] <= w_new;
                r_field     <= w_new;
                r_reflect   <= w_refl;
                r_out_first <= (w_slot == '0);
                r_slot      <= w_slot_nxt;
            end

            // A new error wins over a simultaneous clear.
            if (w_ferr)
                r_frame_err <= 1'b1;
            else if (err_clr)
                r_frame_err <= 1'b0;

            // NOTE: non-blocking writes mean a sample of the same channel in
            // this cycle still sees the old coefficients.
            if (cfg_we && w_cfg_ok) begin
                r_det[cfg_addr] <= cfg_detune;
                r_bw[cfg_addr]  <= cfg_bw;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_first = r_out_first;
    assign field     = r_field;
    assign reflect   = r_reflect;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_cavity_mux_model.sv
// ----------------------------------------------------------------------------
// tb_cavity_mux_model
//
// Directed bench for cavity_mux_model (NCH=4, W=18, BW_DEF=4). A table of
// interleaved samples with hand-computed field/reflect values covers the
// lowpass and detune-coupling behaviour. Hand-written sequences then cover
// stalls, framing errors, configuration timing, a mid-frame reset,
// passthrough and saturation.
// ----------------------------------------------------------------------------
module tb_cavity_mux_model;

    localparam int NCH    = 4;
    localparam int CHW    = 2;
    localparam int W      = 18;
    localparam int BW_DEF = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_first = 1'b0;
    logic signed [W-1:0] drive = '0;
    logic                out_valid;
    logic                out_first;
    logic signed [W-1:0] field;
    logic signed [W-1:0] reflect;
    logic                cfg_we = 1'b0;
    logic [CHW-1:0]      cfg_addr = '0;
    logic signed [17:0]  cfg_detune = '0;
    logic [3:0]          cfg_bw = '0;
    logic                err_clr = 1'b0;
    logic                frame_err;

    int n_checks = 0;
    int n_errors = 0;

    cavity_mux_model #(
        .NCH(NCH), .CHW(CHW), .W(W), .BW_DEF(BW_DEF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .drive     (drive),
        .out_valid (out_valid),
        .out_first (out_first),
        .field     (field),
        .reflect   (reflect),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_detune(cfg_detune),
        .cfg_bw    (cfg_bw),
        .err_clr   (err_clr),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic first;
        int   x;
        logic chk;
        int   f;
        int   r;
        logic of;
    } vec_t;

    vec_t tbl[40];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present one cycle of input at the falling edge; return 1ns after the
    // rising edge that consumed it, where the registered outputs are stable.
    task automatic send(input logic v, input logic f, input int x, input logic clr);
        @(negedge clk);
        in_valid = v;
        in_first = f;
        drive    = W'(x);
        err_clr  = clr;
        @(posedge clk);
        #1;
        cfg_we  = 1'b0;
        err_clr = 1'b0;
    endtask

    // Arm a configuration write for the next rising edge.
    task automatic arm_cfg(input int a, input int d, input int b);
        cfg_we     = 1'b1;
        cfg_addr   = CHW'(a);
        cfg_detune = 18'(d);
        cfg_bw     = 4'(b);
    endtask

    task automatic zeros(input int n);
        for (int i = 0; i < n; i++) send(1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic expect_out(input string tag, input int f, input int r, input logic of);
        check({tag, "_valid"}, int'(out_valid), 1);
        check({tag, "_field"}, int'(field), f);
        check({tag, "_reflect"}, int'(reflect), r);
        check({tag, "_first"}, int'(out_first), int'(of));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ch0_i[5];
        int ch1_i[2];
        int ch1_q[2];
        ch0_i = '{500, 750, 875, 937, 968};
        ch1_i = '{1000, 750};
        ch1_q = '{-500, -375};

        // Table: 5 frames; ch0 I and ch1 I driven with 1000, all else 0.
        // ch0: bw=1, d=0. ch1: bw=0, d=0.5. ch2/ch3 stay at rest.
        for (int f = 0; f < 5; f++) begin
            for (int k = 0; k < 8; k++) begin
                vec_t v;
                v.first = (k == 0);
                v.x     = (k == 0 || k == 2) ? 1000 : 0;
                v.chk   = 1'b1;
                v.f     = 0;
                v.r     = 0;
                v.of    = (k == 0);
                if (k == 0) begin
                    v.f = ch0_i[f];
                    v.r = 1000 - ch0_i[f];
                end else if (k == 2 || k == 3) begin
                    if (f < 2) begin
                        v.f = (k == 2) ? ch1_i[f] : ch1_q[f];
                        v.r = v.x - v.f;
                    end else begin
                        v.chk = 1'b0;
                    end
                end
                tbl[f * 8 + k] = v;
            end
        end

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", int'(out_valid), 0);
        check("rst_first", int'(out_first), 0);
        check("rst_field", int'(field), 0);
        check("rst_reflect", int'(reflect), 0);
        check("rst_frame_err", int'(frame_err), 0);
        @(negedge clk);
        rst = 1'b0;

        arm_cfg(0, 0, 1);
        send(1'b0, 1'b0, 0, 1'b0);
        arm_cfg(1, 65536, 0);
        send(1'b0, 1'b0, 0, 1'b0);
        check("idle_valid", int'(out_valid), 0);

        // ---------------- table-driven lowpass / coupling ----------------
        for (int i = 0; i < 40; i++) begin
            send(1'b1, tbl[i].first, tbl[i].x, 1'b0);
            if (tbl[i].chk)
                expect_out($sformatf("tbl%0d", i), tbl[i].f, tbl[i].r, tbl[i].of);
        end
        check("tbl_frame_err", int'(frame_err), 0);

        // ---------------- stall ----------------
        // Counter is at 0: no in_first needed. ch0 I: 968 + (32>>>1) = 984.
        send(1'b1, 1'b0, 1000, 1'b0);
        expect_out("stall_pre", 984, 16, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send(1'b0, 1'b0, 0, 1'b0);
            check($sformatf("stall%0d_valid", i), int'(out_valid), 0);
            check($sformatf("stall%0d_field", i), int'(field), 984);
            check($sformatf("stall%0d_first", i), int'(out_first), 1);
        end
        // Resumes at slot 1 (ch0 Q), not slot 0.
        send(1'b1, 1'b0, 0, 1'b0);
        expect_out("stall_resume", 0, 0, 1'b0);

        // ---------------- frame error ----------------
        send(1'b1, 1'b0, 0, 1'b0);                   // slot 2, ch1 I
        send(1'b1, 1'b1, 1000, 1'b0);                // slot 3 with in_first -> ch0 I
        expect_out("ferr_sample", 992, 8, 1'b1);
        check("ferr_set", int'(frame_err), 1);
        send(1'b0, 1'b0, 0, 1'b1);
        check("ferr_clr", int'(frame_err), 0);

        // ---------------- config timing ----------------
        send(1'b1, 1'b0, 0, 1'b0);                   // slot 1, ch0 Q
        expect_out("after_err_q", 0, 0, 1'b0);
        zeros(2);                                    // slots 2,3 (ch1)
        arm_cfg(2, 0, 0);
        send(1'b1, 1'b0, 1600, 1'b0);                // ch2 I, old bw=4
        expect_out("cfg_old", 100, 1500, 1'b0);
        send(1'b1, 1'b0, 1600, 1'b0);                // ch2 Q, new bw=0
        expect_out("cfg_new", 1600, 0, 1'b0);

        // Error and clear in the same cycle: error wins.
        send(1'b1, 1'b1, 1000, 1'b1);                // slot 6 with in_first -> ch0 I
        expect_out("ferr2_sample", 996, 4, 1'b1);
        check("ferr_clr_and_set", int'(frame_err), 1);

        // ---------------- mid-frame reset ----------------
        rst      = 1'b1;
        in_valid = 1'b0;
        in_first = 1'b0;
        #1;
        check("mrst_valid", int'(out_valid), 0);
        check("mrst_first", int'(out_first), 0);
        check("mrst_field", int'(field), 0);
        check("mrst_reflect", int'(reflect), 0);
        check("mrst_frame_err", int'(frame_err), 0);
        @(negedge clk);
        rst = 1'b0;

        // First sample without in_first is ch0 I with bw back to 4.
        send(1'b1, 1'b0, 1600, 1'b0);
        expect_out("post_rst", 100, 1500, 1'b1);
        check("post_rst_ferr", int'(frame_err), 0);
        zeros(3);
        send(1'b1, 1'b0, 1600, 1'b0);                // ch2 I: bw back to 4
        expect_out("post_rst_ch2", 100, 1500, 1'b0);

        // ---------------- passthrough (ch3, bw=0, d=0) ----------------
        arm_cfg(3, 0, 0);
        send(1'b1, 1'b0, 0, 1'b0);                   // slot 5, ch2 Q
        send(1'b1, 1'b0, 131071, 1'b0);
        expect_out("pass_max", 131071, 0, 1'b0);
        send(1'b1, 1'b0, -131072, 1'b0);
        expect_out("pass_min", -131072, 0, 1'b0);

        // ---------------- state saturation (ch3, bw=0, d=-1.0) ----------------
        // I: e = 0 + ((-131072 * -131072) >>> 17) = 131072 -> 262143 clamps.
        // Q: e = 0 - ((-131072 * 131071) >>> 17) = 131071 -> yQ = -1.
        arm_cfg(3, -131072, 0);
        zeros(6);
        send(1'b1, 1'b0, 131071, 1'b0);
        expect_out("sat_field", 131071, 0, 1'b0);
        send(1'b1, 1'b0, -131072, 1'b0);
        expect_out("sat_q", -1, -131071, 1'b0);

        // ---------------- reflect saturation (ch3, bw=4, d=0) ----------------
        // e = -262143 >>> 4 = -16384 -> yI = 114687, x - yI = -245759 clamps.
        arm_cfg(3, 0, 4);
        zeros(6);
        send(1'b1, 1'b0, -131072, 1'b0);
        expect_out("sat_reflect", 114687, -131072, 1'b0);
        check("end_frame_err", int'(frame_err), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
